maxpool_stream_ctrl: RTL and testbench

//  Sequences one maxpool_2x2 instance over a raster-scan feature-map stream.

---
 rtl/maxpool_stream_ctrl_pkg.sv | 15 +
 rtl/maxpool_2x2.sv | 21 ++
 rtl/maxpool_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_maxpool_stream_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/maxpool_stream_ctrl_pkg.sv
// Shared frame defaults and controller state encoding for the maxpool stream path.
package maxpool_stream_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int IMG_W_DEF      = 28;
  localparam int IMG_H_DEF      = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/maxpool_2x2.sv
// Combinational signed maximum of a 2x2 window; result keeps the input width.
module maxpool_2x2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a00,
  input  logic signed [DATA_WIDTH-1:0] a01,
  input  logic signed [DATA_WIDTH-1:0] a10,
  input  logic signed [DATA_WIDTH-1:0] a11,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH-1:0] top_max;
  logic signed [DATA_WIDTH-1:0] bot_max;

  always_comb begin
    top_max = (a00 > a01) ? a00 : a01;
    bot_max = (a10 > a11) ? a10 : a11;
    y       = (top_max > bot_max) ? top_max : bot_max;
  end

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Streams a raster feature map through one 2x2 max-pool, buffering even rows in a line buffer.
module maxpool_stream_ctrl
  import maxpool_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int COL_W      = $clog2(IMG_W),
  parameter int ROW_W      = $clog2(IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_WCOL = COL_W'(2 * (IMG_W / 2) - 1);
  localparam logic [ROW_W-1:0] LAST_WROW = ROW_W'(2 * (IMG_H / 2) - 1);

  state_t                  state_reg;
  logic [ROW_W-1:0]        row_reg;
  logic [COL_W-1:0]        col_reg;
  logic [DATA_WIDTH-1:0]   lbuf [IMG_W];
  logic [DATA_WIDTH-1:0]   prev_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic                    out_valid_reg;
  logic                    out_last_reg;
  logic                    busy_reg;
  logic                    done_reg;

  logic                    xfer;
  logic                    win_fire;
  logic                    last_pix;
  logic [COL_W-1:0]        col_m1;
  logic [DATA_WIDTH-1:0]   pool_max;

  assign in_ready  = (state_reg == RUN) && (!out_valid_reg || out_ready);
  assign xfer      = in_valid && in_ready;
  // Odd columns never occur at col IMG_W-1 when IMG_W is odd, same for rows, so the
  // trailing unpaired column/row is consumed without forming a window.
  assign win_fire  = xfer && row_reg[0] && col_reg[0];
  assign last_pix  = (row_reg == LAST_ROW) && (col_reg == LAST_COL);
  assign col_m1    = col_reg - COL_W'(1);

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;

  maxpool_2x2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pool (
    .a00(lbuf[col_m1]),
    .a01(lbuf[col_reg]),
    .a10(prev_reg),
    .a11(in_data),
    .y  (pool_max)
  );

  // Line buffer and left-hand pixel of the odd row carry no reset; they are always
  // written before being read within a frame.
  always_ff @(posedge clk) begin
    if (xfer && !row_reg[0]) begin
      lbuf[col_reg] <= in_data;
    end
    if (xfer && row_reg[0] && !col_reg[0]) begin
      prev_reg <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
      // in_ready guarantees the output slot is empty or being emptied this cycle.
      if (win_fire) begin
        out_data_reg  <= pool_max;
        out_valid_reg <= 1'b1;
        out_last_reg  <= (row_reg == LAST_WROW) && (col_reg == LAST_WCOL);
      end

      if (xfer) begin
        if (col_reg == LAST_COL) begin
          col_reg <= '0;
          row_reg <= last_pix ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            row_reg   <= '0;
            col_reg   <= '0;
          end
        end
        RUN: begin
          if (xfer && last_pix) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid_reg || out_ready) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Directed bench for maxpool_stream_ctrl: 4x4 and 5x5 instances share stimulus, one is observed at a time.
module tb_maxpool_stream_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sel = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;

  logic          busy4, done4, in_ready4, out_valid4, out_last4;
  logic [DW-1:0] out_data4;
  logic          busy5, done5, in_ready5, out_valid5, out_last5;
  logic [DW-1:0] out_data5;

  logic          o_busy, o_done, o_in_ready, o_out_valid, o_out_last;
  logic [DW-1:0] o_out_data;

  int checks = 0;
  int failures = 0;
  int pix [0:31];
  int exp_q [0:3];

  always #5 clk = ~clk;

  maxpool_stream_ctrl #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .busy(busy4), .done(done4),
    .in_data(in_data), .in_valid(in_valid && !sel), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_last(out_last4)
  );

  maxpool_stream_ctrl #(.DATA_WIDTH(DW), .IMG_W(5), .IMG_H(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .busy(busy5), .done(done5),
    .in_data(in_data), .in_valid(in_valid && sel), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready),
    .out_last(out_last5)
  );

  assign o_busy      = sel ? busy5      : busy4;
  assign o_done      = sel ? done5      : done4;
  assign o_in_ready  = sel ? in_ready5  : in_ready4;
  assign o_out_valid = sel ? out_valid5 : out_valid4;
  assign o_out_last  = sel ? out_last5  : out_last4;
  assign o_out_data  = sel ? out_data5  : out_data4;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Runs one frame on the selected instance. rmode 1 throttles out_ready (1 on / 2 off)
  // and gaps in_valid; abort_after > 0 pulls rst_n low once that many inputs were taken.
  task automatic run_frame(input string name, input int npix, input int nexp,
                           input int rmode, input bit restart_mid, input int abort_after);
    int idx = 0;
    int got = 0;
    int dcnt = 0;
    int cyc = 0;
    bit prev_done = 0;
    bit restarted = 0;
    bit stall_prev = 0;
    int held_data = 0;
    int held_last = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check_eq({name, " busy_after_start"}, int'(o_busy), 1);
    while (cyc < 600) begin
      if (abort_after > 0 && idx == abort_after) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq({name, " abort_busy"}, int'(o_busy), 0);
        check_eq({name, " abort_in_ready"}, int'(o_in_ready), 0);
        check_eq({name, " abort_out_valid"}, int'(o_out_valid), 0);
        check_eq({name, " abort_done"}, int'(o_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      start     = (restart_mid && !restarted && idx == 5);
      if (start) restarted = 1;
      in_valid  = (idx < npix) && (rmode == 0 || (cyc % 2) == 0);
      in_data   = (idx < npix) ? DW'(pix[idx]) : DW'(8'h55);
      out_ready = (rmode == 0) || ((cyc % 3) == 0);
      #1;
      if (prev_done) begin
        check_eq({name, " busy_after_done"}, int'(o_busy), 0);
        check_eq({name, " done_width"}, int'(o_done), 0);
        break;
      end
      if (stall_prev) begin
        check_eq({name, " stall_valid"}, int'(o_out_valid), 1);
        check_eq({name, " stall_data"}, int'($signed(o_out_data)), held_data);
        check_eq({name, " stall_last"}, int'(o_out_last), held_last);
      end
      stall_prev = o_out_valid && !out_ready;
      held_data  = int'($signed(o_out_data));
      held_last  = int'(o_out_last);
      if (in_valid && o_in_ready) idx++;
      if (o_out_valid && out_ready) begin
        $display("%s out[%0d] data=%0d last=%0b", name, got, $signed(o_out_data), o_out_last);
        if (got < nexp) begin
          check_eq({name, " out_data"}, int'($signed(o_out_data)), exp_q[got]);
          check_eq({name, " out_last"}, int'(o_out_last), (got == nexp - 1) ? 1 : 0);
        end
        got++;
      end
      if (o_done) begin
        dcnt++;
        prev_done = 1;
        check_eq({name, " inputs_at_done"}, idx, npix);
        check_eq({name, " busy_with_done"}, int'(o_busy), 1);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    check_eq({name, " finished_in_budget"}, int'(prev_done), 1);
    check_eq({name, " output_count"}, got, nexp);
    check_eq({name, " done_pulses"}, dcnt, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst busy", int'(o_busy), 0);
    check_eq("rst done", int'(o_done), 0);
    check_eq("rst in_ready", int'(o_in_ready), 0);
    check_eq("rst out_valid", int'(o_out_valid), 0);
    check_eq("rst out_last", int'(o_out_last), 0);
    check_eq("rst out_data", int'(o_out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) pix[i] = i;
    exp_q[0] = 5; exp_q[1] = 7; exp_q[2] = 13; exp_q[3] = 15;
    run_frame("t1_ramp", 16, 4, 0, 0, 0);

    for (int i = 0; i < 16; i++) pix[i] = -16 + i;
    exp_q[0] = -11; exp_q[1] = -9; exp_q[2] = -3; exp_q[3] = -1;
    run_frame("t2_neg", 16, 4, 0, 0, 0);

    for (int i = 0; i < 16; i++) pix[i] = i;
    exp_q[0] = 5; exp_q[1] = 7; exp_q[2] = 13; exp_q[3] = 15;
    run_frame("t3_stall", 16, 4, 1, 0, 0);

    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 25; i++) pix[i] = i;
    exp_q[0] = 6; exp_q[1] = 8; exp_q[2] = 16; exp_q[3] = 18;
    run_frame("t4_5x5", 25, 4, 0, 0, 0);
    sel = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) pix[i] = i;
    exp_q[0] = 5; exp_q[1] = 7; exp_q[2] = 13; exp_q[3] = 15;
    run_frame("t5_restart", 16, 4, 0, 1, 0);

    for (int i = 0; i < 16; i++) pix[i] = 100 - i;
    run_frame("t6_abort", 16, 4, 0, 0, 6);
    for (int i = 0; i < 16; i++) pix[i] = i;
    run_frame("t6_after", 16, 4, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
